vx_tcu_drl_norm: RTL and testbench

VX_TCU_DRL_NORM -- requirements
Module: VX_tcu_drl_norm

---
 rtl/vx_tcu_drl_norm_pkg.sv | 47 ++++
 rtl/vx_tcu_drl_norm_lzc.sv | 25 ++
 rtl/vx_tcu_drl_norm.sv | 232 +++++++++++++++++++++++
 tb/tb_vx_tcu_drl_norm.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_tcu_drl_norm_pkg.sv
// -----------------------------------------------------------------------------
// vx_tcu_drl_norm_pkg
// Shared constants for the tensor-core dot-product-result normalizer:
//   - rounding-mode encoding (only round-to-nearest-even is used today)
//   - bit positions of the {OF, UF, NX} exception flags
//   - internal exponent width and a rounding-increment helper
// -----------------------------------------------------------------------------
package vx_tcu_drl_norm_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,  // nearest, ties to even
    RM_RTZ = 3'd1,  // toward zero
    RM_RDN = 3'd2,  // toward -inf
    RM_RUP = 3'd3,  // toward +inf
    RM_RMM = 3'd4   // nearest, ties away from zero
  } rnd_mode_e;

  // fflags = {OF, UF, NX}
  localparam int FFLAG_NX = 0;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_W  = 3;

  // Signed biased exponent width inside the pipe; wide enough for
  // exp_in (10 b unsigned) plus the msb position and a rounding carry.
  localparam int EXP_W = 12;

  // Returns 1 when the truncated mantissa must be incremented by one ulp.
  function automatic logic round_inc(input rnd_mode_e rm,
                                     input logic      sign,
                                     input logic      lsb,
                                     input logic      guard,
                                     input logic      sticky);
    logic inc;
    inc = 1'b0;
    case (rm)
      RM_RNE:  inc = guard & (lsb | sticky);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & (guard | sticky);
      RM_RUP:  inc = ~sign & (guard | sticky);
      RM_RMM:  inc = guard;
      default: inc = 1'b0;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/vx_tcu_drl_norm_lzc.sv
// -----------------------------------------------------------------------------
// vx_tcu_drl_norm_lzc
// Combinational leading-zero counter.
//   data_in : N-bit vector
//   cnt_out : number of zeros above the most significant set bit
//             (0 when data_in is all zero; callers detect zero separately)
// -----------------------------------------------------------------------------
module vx_tcu_drl_norm_lzc #(
  parameter int N = 30
) (
  input  logic [N-1:0]         data_in,
  output logic [$clog2(N)-1:0] cnt_out
);

  localparam int CW = $clog2(N);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    cnt_out = '0;
    for (int i = 0; i < N; i++) begin
      if (data_in[i]) cnt_out = CW'(N - 1 - i);
    end
  end

endmodule

// File: rtl/vx_tcu_drl_norm.sv
// -----------------------------------------------------------------------------
// vx_tcu_drl_norm
// Normalizes a signed fixed-point accumulator sum and packs it into IEEE-754
// binary32 (round-to-nearest-even, no subnormals). Three-stage elastic pipe:
//   S0 sign/abs -> S1 leading-zero count + left shift -> S2 round + pack
//
// Ports
//   clk, reset             single clock, asynchronous active-high reset
//   valid_in / ready_in    input handshake (transfer on valid_in & ready_in)
//   req_id_in [31:0]       request tag, carried alongside the data
//   sig_in [WA-1:0]        signed significand, value = sig x 2^(exp-127-FRAC)
//   sticky_in              OR of bits already discarded upstream
//   exp_in [9:0]           unsigned biased common exponent
//   valid_out / ready_out  output handshake
//   req_id_out [31:0]      tag of the result beat
//   result [31:0]          binary32 result
//   fflags [2:0]           {OF, UF, NX}
// -----------------------------------------------------------------------------
module vx_tcu_drl_norm
  import vx_tcu_drl_norm_pkg::*;
#(
  parameter string INSTANCE_ID = "",
  parameter int    WA          = 30,
  parameter int    FRAC        = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_in,
  output logic          ready_in,
  input  logic [31:0]   req_id_in,
  input  logic [WA-1:0] sig_in,
  input  logic          sticky_in,
  input  logic [9:0]    exp_in,
  output logic          valid_out,
  input  logic          ready_out,
  output logic [31:0]   req_id_out,
  output logic [31:0]   result,
  output logic [2:0]    fflags
);

  localparam int LZW = $clog2(WA);
  // Normalized magnitude padded with two zero lsbs so that mantissa, guard
  // and sticky slices exist for any WA >= 24.
  localparam int NW  = WA + 2;

  localparam logic signed [EXP_W-1:0] EXP_INF  = EXP_W'(255);
  localparam logic signed [EXP_W-1:0] EXP_ZERO = '0;

  // ---------------------------------------------------------------------------
  // Handshake chain: a stage may load when empty or when it drains this cycle.
  // ---------------------------------------------------------------------------
  logic s0_valid_q, s0_valid_d;
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;

  logic s0_ready, s1_ready, s2_ready;
  logic s0_load, s1_load, s2_load;

  assign s2_ready = !s2_valid_q || ready_out;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign s0_ready = !s0_valid_q || s1_ready;

  assign s0_load  = valid_in   && s0_ready;
  assign s1_load  = s0_valid_q && s1_ready;
  assign s2_load  = s1_valid_q && s2_ready;

  assign ready_in = s0_ready;

  always_comb begin
    s0_valid_d = s0_ready ? valid_in   : s0_valid_q;
    s1_valid_d = s1_ready ? s0_valid_q : s1_valid_q;
    s2_valid_d = s2_ready ? s1_valid_q : s2_valid_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_valid_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbours, independent of order.
      s0_valid_q <= s0_valid_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // S0: sign / absolute value. The most negative input maps to 2^(WA-1),
  // which is representable as WA-bit unsigned.
  // ---------------------------------------------------------------------------
  logic          s0_sign_q,   s0_sign_d;
  logic [WA-1:0] s0_mag_q,    s0_mag_d;
  logic          s0_sticky_q, s0_sticky_d;
  logic [9:0]    s0_exp_q,    s0_exp_d;
  logic [31:0]   s0_id_q,     s0_id_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first (here: hold), so no
    // path leaves a variable unassigned and no latch is inferred.
    s0_sign_d   = s0_sign_q;
    s0_mag_d    = s0_mag_q;
    s0_sticky_d = s0_sticky_q;
    s0_exp_d    = s0_exp_q;
    s0_id_d     = s0_id_q;
    if (s0_load) begin
      s0_sign_d   = sig_in[WA-1];
      s0_mag_d    = sig_in[WA-1] ? (~sig_in + WA'(1)) : sig_in;
      s0_sticky_d = sticky_in;
      s0_exp_d    = exp_in;
      s0_id_d     = req_id_in;
    end
  end

  // ---------------------------------------------------------------------------
  // S1: leading-zero count, left shift, biased exponent
  //   E = exp_in - FRAC + p,  p = WA-1-lz
  // ---------------------------------------------------------------------------
  logic [LZW-1:0]          s0_lz;
  logic                    s1_sign_q,   s1_sign_d;
  logic [WA-1:0]           s1_norm_q,   s1_norm_d;
  logic                    s1_sticky_q, s1_sticky_d;
  logic signed [EXP_W-1:0] s1_exp_q,    s1_exp_d;
  logic [31:0]             s1_id_q,     s1_id_d;

  vx_tcu_drl_norm_lzc #(
    .N (WA)
  ) u_lzc (
    .data_in (s0_mag_q),
    .cnt_out (s0_lz)
  );

  always_comb begin
    s1_sign_d   = s1_sign_q;
    s1_norm_d   = s1_norm_q;
    s1_sticky_d = s1_sticky_q;
    s1_exp_d    = s1_exp_q;
    s1_id_d     = s1_id_q;
    if (s1_load) begin
      s1_sign_d   = s0_sign_q;
      s1_norm_d   = s0_mag_q << s0_lz;
      s1_sticky_d = s0_sticky_q;
      s1_exp_d    = EXP_W'(s0_exp_q) + EXP_W'(WA - 1 - FRAC) - EXP_W'(s0_lz);
      s1_id_d     = s0_id_q;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: round to nearest even and pack. After normalization the msb of the
  // shifted magnitude is 1 unless the magnitude was zero.
  // ---------------------------------------------------------------------------
  logic [NW-1:0]           s2_ext;
  logic                    s2_zero;
  logic [22:0]             s2_mant;
  logic                    s2_guard;
  logic                    s2_rsticky;
  logic                    s2_inc;
  logic [23:0]             s2_mant_r;
  logic signed [EXP_W-1:0] s2_exp_r;
  logic [31:0]             s2_pack;
  logic [FFLAG_W-1:0]      s2_flags;

  logic [31:0]             s2_result_q, s2_result_d;
  logic [2:0]              s2_fflags_q, s2_fflags_d;
  logic [31:0]             s2_id_q,     s2_id_d;

  always_comb begin
    s2_ext     = {s1_norm_q, 2'b00};
    s2_zero    = !s2_ext[NW-1];
    s2_mant    = s2_ext[NW-2 -: 23];
    s2_guard   = s2_ext[NW-25];
    s2_rsticky = (|s2_ext[NW-26:0]) | s1_sticky_q;
    s2_inc     = round_inc(RM_RNE, s1_sign_q, s2_mant[0], s2_guard, s2_rsticky);

    // A carry out of the 23-bit mantissa leaves it all zero and bumps E.
    s2_mant_r  = {1'b0, s2_mant} + 24'(s2_inc);
    s2_exp_r   = s1_exp_q + EXP_W'(s2_mant_r[23]);

    s2_flags   = '0;
    if (s2_zero) begin
      s2_pack            = 32'h0000_0000;
      s2_flags[FFLAG_NX] = s1_sticky_q;
    end else if (s2_exp_r >= EXP_INF) begin
      s2_pack            = {s1_sign_q, 8'hFF, 23'd0};
      s2_flags[FFLAG_OF] = 1'b1;
      s2_flags[FFLAG_NX] = 1'b1;
    end else if (s2_exp_r <= EXP_ZERO) begin
      s2_pack            = {s1_sign_q, 31'd0};
      s2_flags[FFLAG_UF] = 1'b1;
      s2_flags[FFLAG_NX] = 1'b1;
    end else begin
      s2_pack            = {s1_sign_q, s2_exp_r[7:0], s2_mant_r[22:0]};
      s2_flags[FFLAG_NX] = s2_guard | s2_rsticky;
    end

    s2_result_d = s2_result_q;
    s2_fflags_d = s2_fflags_q;
    s2_id_d     = s2_id_q;
    if (s2_load) begin
      s2_result_d = s2_pack;
      s2_fflags_d = s2_flags;
      s2_id_d     = s1_id_q;
    end
  end

  // NOTE: datapath registers carry no reset; the valid bits alone decide
  // whether their contents mean anything, so resetting them buys nothing.
  always_ff @(posedge clk) begin
    s0_sign_q   <= s0_sign_d;
    s0_mag_q    <= s0_mag_d;
    s0_sticky_q <= s0_sticky_d;
    s0_exp_q    <= s0_exp_d;
    s0_id_q     <= s0_id_d;

    s1_sign_q   <= s1_sign_d;
    s1_norm_q   <= s1_norm_d;
    s1_sticky_q <= s1_sticky_d;
    s1_exp_q    <= s1_exp_d;
    s1_id_q     <= s1_id_d;

    s2_result_q <= s2_result_d;
    s2_fflags_q <= s2_fflags_d;
    s2_id_q     <= s2_id_d;
  end

  assign valid_out  = s2_valid_q;
  assign result     = s2_result_q;
  assign fflags     = s2_fflags_q;
  assign req_id_out = s2_id_q;

endmodule

// File: tb/tb_vx_tcu_drl_norm.sv
module tb_vx_tcu_drl_norm;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] req_id_in;
  logic [29:0] sig_in;
  logic        sticky_in;
  logic [9:0]  exp_in;
  logic        valid_out;
  logic        ready_out;
  logic [31:0] req_id_out;
  logic [31:0] result;
  logic [2:0]  fflags;

  always #5 clk = ~clk;

  vx_tcu_drl_norm #(
    .INSTANCE_ID ("norm0"),
    .WA          (30),
    .FRAC        (24)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .ready_in   (ready_in),
    .req_id_in  (req_id_in),
    .sig_in     (sig_in),
    .sticky_in  (sticky_in),
    .exp_in     (exp_in),
    .valid_out  (valid_out),
    .ready_out  (ready_out),
    .req_id_out (req_id_out),
    .result     (result),
    .fflags     (fflags)
  );

  typedef struct {
    logic [31:0] id;
    logic [31:0] res;
    logic [2:0]  ff;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] dropped[$];
  logic [34:0] cur_want;   // {fflags, result} of the beat being driven
  int          total = 0;
  int          bad   = 0;
  bit          rand_done = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference: round the exact magnitude to 24 significant bits with
  // integer arithmetic, ties to even, sticky_in counting as "above half".
  function automatic logic [34:0] model(input logic [29:0] sig, input logic stk,
                                        input logic [9:0] ex);
    logic        sgn;
    longint      mag, q, rem, half;
    int          p, e, sh;
    logic        nx, up;
    logic [31:0] r;
    logic [2:0]  f;
    sgn = sig[29];
    mag = sgn ? (64'd1 << 30) - longint'(sig) : longint'(sig);
    if (mag == 0) return {2'b00, stk, 32'h0};
    p = 0;
    for (int i = 0; i < 30; i++) if (((mag >> i) & 1) != 0) p = i;
    e = int'(ex) - 24 + p;
    if (p > 23) begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      up   = (rem > half) || (rem == half && (stk || (q & 1) != 0));
      nx   = (rem != 0) || stk;
    end else begin
      q  = mag << (23 - p);
      up = 1'b0;
      nx = stk;
    end
    q = q + longint'(up);
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) begin
      r = {sgn, 8'hFF, 23'd0}; f = 3'b101;
    end else if (e <= 0) begin
      r = {sgn, 31'd0}; f = 3'b011;
    end else begin
      r = {sgn, 8'(e), 23'(q)}; f = {2'b00, nx};
    end
    return {f, r};
  endfunction

  // Scoreboard: push on accepted input, pop and compare on accepted output.
  always @(negedge clk) begin
    if (!reset) begin
      if (valid_out && ready_out) begin
        bit hit;
        hit = 1'b0;
        foreach (dropped[i]) if (dropped[i] == req_id_out) hit = 1'b1;
        if (dropped.size() != 0) check("dropped_tag_seen", 64'(hit), 64'd0);
        if (sb.size() == 0) begin
          check("unexpected_out", 64'(sb.size()), 64'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("req_id", 64'(req_id_out), 64'(e.id));
          check("result", 64'(result), 64'(e.res));
          check("fflags", 64'(fflags), 64'(e.ff));
        end
      end
      if (valid_in && ready_in) begin
        exp_t e;
        e.id  = req_id_in;
        e.res = cur_want[31:0];
        e.ff  = cur_want[34:32];
        sb.push_back(e);
      end
    end
  end

  task automatic send(input logic [31:0] id, input logic [29:0] sig, input logic stk,
                      input logic [9:0] ex, input logic [34:0] want);
    int n;
    cur_want  = want;
    valid_in  = 1'b1;
    req_id_in = id;
    sig_in    = sig;
    sticky_in = stk;
    exp_in    = ex;
    n = 0;
    @(negedge clk);
    while (!ready_in && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check("send_timeout", 64'(n), 64'd0);
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  typedef struct {
    logic [29:0] sig;
    logic        stk;
    logic [9:0]  ex;
    logic [31:0] res;
    logic [2:0]  ff;
  } vec_t;

  vec_t vecs[] = '{
    '{30'h1000000,  1'b0, 10'd127, 32'h3F80_0000, 3'b000},  // 1.0
    '{30'h3E800000, 1'b0, 10'd127, 32'hBFC0_0000, 3'b000},  // -1.5
    '{30'h1000001,  1'b0, 10'd127, 32'h3F80_0000, 3'b001},  // tie -> even
    '{30'h1000003,  1'b0, 10'd127, 32'h3F80_0002, 3'b001},  // tie -> up
    '{30'h1000001,  1'b1, 10'd127, 32'h3F80_0001, 3'b001},  // sticky breaks tie
    '{30'h1000000,  1'b0, 10'd300, 32'h7F80_0000, 3'b101},  // overflow
    '{30'h3F000000, 1'b0, 10'd300, 32'hFF80_0000, 3'b101},  // -overflow
    '{30'h1000000,  1'b0, 10'd0,   32'h0000_0000, 3'b011},  // underflow
    '{30'h3F000000, 1'b0, 10'd0,   32'h8000_0000, 3'b011},  // -underflow
    '{30'h0000000,  1'b1, 10'd127, 32'h0000_0000, 3'b001},  // zero, sticky
    '{30'h0000000,  1'b0, 10'd200, 32'h0000_0000, 3'b000},  // zero
    '{30'h20000000, 1'b0, 10'd127, 32'hC200_0000, 3'b000},  // most negative: -32.0
    '{30'h1FFFFFF,  1'b0, 10'd127, 32'h4000_0000, 3'b001},  // mantissa carry
    '{30'h1FFFFFF,  1'b0, 10'd254, 32'h7F80_0000, 3'b101},  // carry into inf
    '{30'h0000001,  1'b0, 10'd127, 32'h3380_0000, 3'b000}   // 2^-24
  };

  initial begin
    reset     = 1'b1;
    valid_in  = 1'b0;
    ready_out = 1'b1;
    req_id_in = '0;
    sig_in    = '0;
    sticky_in = 1'b0;
    exp_in    = '0;
    cur_want  = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_out", 64'(valid_out), 64'd0);
    check("rst_ready_in", 64'(ready_in), 64'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_valid_out", 64'(valid_out), 64'd0);
    check("post_rst_ready_in", 64'(ready_in), 64'd1);

    // Latency: output appears exactly three cycles after acceptance.
    send(32'd100, 30'h1000000, 1'b0, 10'd127, {3'b000, 32'h3F80_0000});
    check("lat_c1", 64'(valid_out), 64'd0);
    @(posedge clk); #1;
    check("lat_c2", 64'(valid_out), 64'd0);
    @(posedge clk); #1;
    check("lat_c3", 64'(valid_out), 64'd1);
    @(posedge clk); #1;
    check("lat_single", 64'(valid_out), 64'd0);

    // Directed vectors back to back.
    foreach (vecs[i])
      send(32'd200 + 32'(i), vecs[i].sig, vecs[i].stk, vecs[i].ex, {vecs[i].ff, vecs[i].res});
    drain("drain_directed");

    // Backpressure: three beats held, fourth stalls, then in-order release.
    ready_out = 1'b0;
    for (int t = 1; t <= 3; t++)
      send(32'(t), 30'h1000000 + 30'(t), 1'b0, 10'd127, model(30'h1000000 + 30'(t), 1'b0, 10'd127));
    cur_want  = model(30'h1000004, 1'b0, 10'd127);
    valid_in  = 1'b1;
    req_id_in = 32'd4;
    sig_in    = 30'h1000004;
    sticky_in = 1'b0;
    exp_in    = 10'd127;
    check("full_ready_in", 64'(ready_in), 64'd0);
    check("full_valid_out", 64'(valid_out), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    check("stall_ready_in", 64'(ready_in), 64'd0);
    check("stall_id", 64'(req_id_out), 64'd1);
    ready_out = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("release_valid", 64'(valid_out), 64'd1);
      check("release_order", 64'(req_id_out), 64'(k + 1));
      @(posedge clk); #1;
      if (k == 0) valid_in = 1'b0;
    end
    drain("drain_bp");

    // Reset with three beats in flight: all of them vanish.
    ready_out = 1'b0;
    for (int t = 0; t < 3; t++)
      send(32'hD0 + 32'(t), 30'h1800000, 1'b0, 10'd130, model(30'h1800000, 1'b0, 10'd130));
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_valid_out", 64'(valid_out), 64'd0);
    sb.delete();
    for (int t = 0; t < 3; t++) dropped.push_back(32'hD0 + 32'(t));
    @(posedge clk); @(posedge clk); #1;
    reset     = 1'b0;
    ready_out = 1'b1;
    check("rst_mid_ready_in", 64'(ready_in), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("rst_mid_quiet", 64'(valid_out), 64'd0);
    end

    // Random traffic with random backpressure, checked against the model.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [31:0] r;
          logic [29:0] s;
          logic        st;
          logic [9:0]  ex;
          r = $urandom() >> $urandom_range(2, 31);
          if ($urandom_range(0, 1) == 1) r = -r;
          s  = r[29:0];
          if ($urandom_range(0, 15) == 0) s = 30'h20000000;
          st = ($urandom_range(0, 3) == 0);
          ex = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                           : 10'($urandom_range(90, 180));
          send(32'h1000 + 32'(i), s, st, ex, model(s, st, ex));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          ready_out = ($urandom_range(0, 3) != 0);
        end
      end
    join
    ready_out = 1'b1;
    drain("drain_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "global timeout");
  end

endmodule
